// File: rtl/dds_phase_accumulator_pkg.sv
// rtl/dds_phase_accumulator_pkg.sv - shared types and constants for the DDS phase stage
// Contents:
//   PHASE_W     phase index width fed to the amplitude stage
//   ACC_W_DEF   default accumulator width
//   dds_state_t accumulator FSM state (IDLE, RUN, PENDING)
//   ftw_t       tuning word at the default accumulator width
//   FTW_UNIT    tuning word that advances the phase index by one step per cycle
package dds_pkg;

  localparam int PHASE_W   = 10;
  localparam int ACC_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PENDING = 2'd2
  } dds_state_t;

  typedef logic [ACC_W_DEF-1:0] ftw_t;

  localparam ftw_t FTW_UNIT = ftw_t'(1) << (ACC_W_DEF - PHASE_W);

endpackage

// File: rtl/dds_phase_accumulator_ftw_buffer.sv
// rtl/dds_phase_accumulator_ftw_buffer.sv - FTW handshake with active/pending tuning-word registers
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   state         current accumulator FSM state
//   sync_update   0 = load active FTW on acceptance, 1 = park it until the next wrap
//   ftw_valid     new FTW offered
//   ftw_data      new FTW value
//   apply_pend    move the pending FTW into the active register this edge
//   ftw_ready     an FTW can be accepted this cycle
//   load_pend     an FTW is being parked this edge (FSM enters PENDING)
//   ftw_act       active FTW used by the accumulator
module dds_ftw_buffer
  import dds_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  dds_state_t       state,
  input  logic             sync_update,
  input  logic             ftw_valid,
  input  logic [ACC_W-1:0] ftw_data,
  input  logic             apply_pend,
  output logic             ftw_ready,
  output logic             load_pend,
  output logic [ACC_W-1:0] ftw_act
);

  logic [ACC_W-1:0] ftw_pend;
  logic             accept;
  logic             load_act;

  // Ready drops with reset so nothing is accepted on a reset edge.
  assign ftw_ready = (state != PENDING) && !reset;
  assign accept    = ftw_valid && ftw_ready;

  // When idle there is no running phase to keep continuous, so even a
  // deferred update takes effect at once.
  assign load_act  = accept && ((state == IDLE) || !sync_update);
  assign load_pend = accept && sync_update && (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      ftw_act  <= '0;
      ftw_pend <= '0;
    end else begin
      if (load_act) begin
        ftw_act <= ftw_data;
      end else if (apply_pend) begin
        ftw_act <= ftw_pend;
      end
      if (load_pend) begin
        ftw_pend <= ftw_data;
      end
    end
  end

endmodule

// File: rtl/dds_phase_accumulator.sv
// rtl/dds_phase_accumulator.sv - DDS phase accumulator producing a 10-bit phase index
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   enable        accumulate when high, hold when low
//   phase_clr     synchronous accumulator clear (also applies a pending FTW)
//   sync_update   FTW apply mode sampled at acceptance (0 immediate, 1 at next wrap)
//   ftw_valid     new FTW offered
//   ftw_data      new FTW value
//   ftw_ready     FTW can be accepted
//   phase_offset  static offset added to the phase index mod 1024
//   phase         registered phase index to phase_to_amplitude
//   wrap          one-cycle pulse after an accumulator carry-out
module dds_phase_accumulator #(
  parameter int ACC_W   = dds_pkg::ACC_W_DEF,
  parameter int PHASE_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               phase_clr,
  input  logic               sync_update,
  input  logic               ftw_valid,
  input  logic [ACC_W-1:0]   ftw_data,
  output logic               ftw_ready,
  input  logic [PHASE_W-1:0] phase_offset,
  output logic [PHASE_W-1:0] phase,
  output logic               wrap
);

  import dds_pkg::*;

  dds_state_t       state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] ftw_act;
  logic             carry;
  logic             apply_pend;
  logic             load_pend;

  dds_ftw_buffer #(.ACC_W(ACC_W)) u_ftw_buffer (
    .clk         (clk),
    .reset       (reset),
    .state       (state),
    .sync_update (sync_update),
    .ftw_valid   (ftw_valid),
    .ftw_data    (ftw_data),
    .apply_pend  (apply_pend),
    .ftw_ready   (ftw_ready),
    .load_pend   (load_pend),
    .ftw_act     (ftw_act)
  );

  assign {carry, sum} = {1'b0, acc} + {1'b0, ftw_act};

  // A clear is a phase discontinuity anyway, so the parked FTW goes in with it.
  assign apply_pend = (state == PENDING) && (phase_clr || (enable && carry));

  always_comb begin
    acc_next = acc;
    if (reset || phase_clr) begin
      acc_next = '0;
    end else if (enable) begin
      acc_next = sum;
    end
  end

  always_ff @(posedge clk) begin
    acc <= acc_next;
    // Built from acc_next so phase always matches the acc it sits beside.
    phase <= acc_next[ACC_W-1 -: PHASE_W] + phase_offset;
    if (reset) begin
      state <= IDLE;
      wrap  <= 1'b0;
    end else begin
      wrap <= enable && carry && !phase_clr;
      case (state)
        IDLE: begin
          if (enable) state <= RUN;
        end
        RUN: begin
          if (load_pend)    state <= PENDING;
          else if (!enable) state <= IDLE;
        end
        PENDING: begin
          if (apply_pend) state <= enable ? RUN : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
